mem_ls_unit: RTL and testbench
==============================

MEM_LS_UNIT -- requirements
Module: mem_ls_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data path width (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 32, data memory address width.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ex_valid_i in 1 and ex_ready_o out 1, the EX->MEM handshake; transfer occurs when both are high.
REQ-006 SHALL have ports ex_load_i, ex_store_i, ex_sign_i (1 each) and ex_size_i (2); size 0=byte, 1=half, 2=word, 3=dword (legal only when DATA_W=64).
REQ-007 SHALL have ports ex_addr_i (ADDR_W), ex_wdata_i (DATA_W), ex_result_i (DATA_W), ex_wdest_i (5), ex_we_i (1), ex_pc_i (32).
REQ-008 SHALL have ports dm_req_o, dm_we_o (1 each), dm_addr_o (ADDR_W), dm_be_o (DATA_W/8, active-high byte enables) and dm_wdata_o (DATA_W).
REQ-009 SHALL have ports dm_gnt_i (1; request accepted), dm_rvalid_i (1; response, for loads and stores) and dm_rdata_i (DATA_W).
REQ-010 SHALL have ports wb_valid_o out 1, wb_ready_i in 1, wb_wdest_o (5), wb_we_o (1), wb_result_o (DATA_W), wb_pc_o (32), wb_misalign_o (1).
REQ-011 SHALL have port ctl_mem_dest_o  out  5  destination of the held op while not IDLE and ex_we=1, else 0 (hazard detection).

Function
REQ-012 SHALL implement states IDLE, REQ, WAIT, DONE.
REQ-013 ex_ready_o SHALL be 1 in IDLE, and in DONE when wb_ready_i=1; 0 otherwise.
REQ-014 On transfer of a non-memory op: latch fields, go to DONE; wb_valid_o rises next cycle with wb_result_o=ex_result_i.
REQ-015 On transfer of a load/store with naturally aligned address: latch, go to REQ.
REQ-016 Misaligned address (addr mod bytes(size) != 0) or size 3 with DATA_W=32: no dm_req_o; go to DONE with wb_misalign_o=1, wb_we_o=0.
REQ-017 In REQ, dm_req_o=1 with dm_addr_o, dm_we_o, dm_be_o, dm_wdata_o held stable until dm_gnt_i=1; then WAIT, or directly DONE if dm_rvalid_i=1 in the same cycle.
REQ-018 In WAIT, stay until dm_rvalid_i=1; then capture result and go to DONE.
REQ-019 dm_be_o SHALL be a size-wide mask of ones shifted left by the byte lane addr[log2(DATA_W/8)-1:0]; dm_wdata_o SHALL be the low size bytes of store data replicated across all lanes.
REQ-020 Load result: dm_rdata_i shifted right by lane*8, truncated to size, sign-extended if ex_sign_i=1 else zero-extended; full-width loads pass unchanged.
REQ-021 Store completion SHALL give wb_result_o=ex_result_i, wb_we_o=0.
REQ-022 In DONE, wb_valid_o=1 and all wb_* stable until wb_ready_i=1; with ex_valid_i=1 in that cycle the next op is accepted (back-to-back, no bubble).
REQ-023 dm_rvalid_i in IDLE or REQ SHALL be ignored.

Reset
REQ-024 rst_n=0 SHALL force IDLE asynchronously; dm_req_o, dm_we_o, wb_valid_o, wb_we_o, wb_misalign_o = 0; dm_be_o, dm_addr_o, dm_wdata_o, wb_result_o, wb_pc_o, wb_wdest_o, ctl_mem_dest_o = 0.
REQ-025 Reset mid-transaction SHALL abandon the op; any later dm_rvalid_i belonging to it is dropped per REQ-023.

Structure
REQ-026 Package mem_pkg SHALL hold size encodings, state enum, and a bytes(size) helper constant table.
REQ-027 Combinational sub-module mem_align SHALL implement REQ-016 check, REQ-019 and REQ-020; FSM and registers stay in mem_ls_unit.

Verification
REQ-028 DATA_W=32, lb signed at 0x103, dm_rdata_i=0x80FF_0000, gnt cycle 1, rvalid cycle 3 -> dm_be_o=4'b1000, wb_result_o=0xFFFF_FF80, wb_valid_o 4 cycles after transfer.
REQ-029 sh at 0x202, data 0x1234_ABCD -> dm_be_o=4'b1100, dm_wdata_o=0xABCD_ABCD, wb_we_o=0.
REQ-030 lw at 0x102 -> no dm_req_o, wb_misalign_o=1 next cycle, wb_we_o=0.
REQ-031 DATA_W=64, ld unsigned word at 0x4 with rdata 0xDEADBEEF_00000001 -> dm_be_o=8'hF0, wb_result_o=0x00000000_DEADBEEF.
REQ-032 wb_ready_i=0 for 5 cycles in DONE -> wb_* stable, ex_ready_o=0; then wb_ready_i=1 with ex_valid_i=1 -> new op accepted same cycle.
REQ-033 rst_n low in WAIT, rvalid arrives after release -> ignored, state IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the load/store unit: access-size encodings, the
// transaction state enum and a bytes-per-size lookup table.
// -----------------------------------------------------------------------------
package mem_pkg;

  // Access size as carried on ex_size_i.
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  // Lifetime of one EX->MEM operation.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Number of bytes touched by each size encoding.
  localparam logic [3:0] SIZE_BYTES [4] = '{4'd1, 4'd2, 4'd4, 4'd8};

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return SIZE_BYTES[size];
  endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Purely combinational data alignment for the load/store unit.
//   Request side : addr_lo_i, req_size_i, req_wdata_i
//                  -> misalign_o, be_o (byte enables), wdata_o (lane-replicated)
//   Response side: rsp_lane_i, rsp_size_i, rsp_sign_i, rsp_rdata_i
//                  -> rsp_result_o (shifted down, truncated, sign/zero-extended)
// -----------------------------------------------------------------------------
module mem_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LANE_W = $clog2(NB)
) (
  input  logic [2:0]        addr_lo_i,
  input  logic [1:0]        req_size_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              misalign_o,
  output logic [NB-1:0]     be_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [LANE_W-1:0] rsp_lane_i,
  input  logic [1:0]        rsp_size_i,
  input  logic              rsp_sign_i,
  input  logic [DATA_W-1:0] rsp_rdata_i,
  output logic [DATA_W-1:0] rsp_result_o
);

  logic [7:0]        be_mask_s;
  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] keep_s;
  logic [6:0]        drop_s;
  logic              sext_s;

  // Request side: alignment check, byte enables and store-data replication.
  always_comb begin
    be_mask_s  = 8'h00;
    wdata_o    = req_wdata_i;
    // Low address bits must be zero below the access size; a dword access
    // is never legal on a 32-bit data path.
    misalign_o = (|(addr_lo_i & 3'(size_bytes(req_size_i) - 4'd1))) |
                 ((req_size_i == 2'd3) & (DATA_W != 64));
    case (size_e'(req_size_i))
      SIZE_B: begin
        be_mask_s = 8'h01;
        wdata_o   = {NB{req_wdata_i[7:0]}};
      end
      SIZE_H: begin
        be_mask_s = 8'h03;
        wdata_o   = {(NB/2){req_wdata_i[15:0]}};
      end
      SIZE_W: begin
        be_mask_s = 8'h0F;
        wdata_o   = {(NB/4){req_wdata_i[31:0]}};
      end
      SIZE_D: begin
        be_mask_s = 8'hFF;
        wdata_o   = req_wdata_i;
      end
      default: begin
        be_mask_s = 8'h00;
        wdata_o   = req_wdata_i;
      end
    endcase
    be_o = NB'(be_mask_s << addr_lo_i[LANE_W-1:0]);
  end

  // Response side: bring the addressed lane to bit 0 and extend to full width.
  always_comb begin
    shifted_s = rsp_rdata_i >> {rsp_lane_i, 3'b000};
    drop_s    = 7'd0;
    sext_s    = 1'b0;
    case (size_e'(rsp_size_i))
      SIZE_B: begin
        drop_s = 7'(DATA_W - 8);
        sext_s = shifted_s[7];
      end
      SIZE_H: begin
        drop_s = 7'(DATA_W - 16);
        sext_s = shifted_s[15];
      end
      SIZE_W: begin
        drop_s = 7'(DATA_W - 32);
        sext_s = shifted_s[31];
      end
      SIZE_D: begin
        drop_s = 7'd0;
        sext_s = shifted_s[DATA_W-1];
      end
      default: begin
        drop_s = 7'd0;
        sext_s = 1'b0;
      end
    endcase
    keep_s       = {DATA_W{1'b1}} >> drop_s;
    rsp_result_o = (shifted_s & keep_s) | ({DATA_W{sext_s & rsp_sign_i}} & ~keep_s);
  end

endmodule

// File: rtl/mem_ls_unit.sv
// -----------------------------------------------------------------------------
// mem_ls_unit
// MEM-stage load/store unit. Accepts one op at a time from EX, issues at most
// one data-memory request, and presents the completed op to writeback.
//   ex_*   : EX->MEM op with valid/ready handshake
//   dm_*   : data memory request (req/gnt) and response (rvalid/rdata)
//   wb_*   : MEM->WB result with valid/ready handshake, plus misalign flag
//   ctl_mem_dest_o : destination register of the held op for hazard logic
// -----------------------------------------------------------------------------
module mem_ls_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LANE_W = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              ex_load_i,
  input  logic              ex_store_i,
  input  logic              ex_sign_i,
  input  logic [1:0]        ex_size_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic [4:0]        ex_wdest_i,
  input  logic              ex_we_i,
  input  logic [31:0]       ex_pc_i,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [NB-1:0]     dm_be_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  input  logic              dm_gnt_i,
  input  logic              dm_rvalid_i,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [4:0]        wb_wdest_o,
  output logic              wb_we_o,
  output logic [DATA_W-1:0] wb_result_o,
  output logic [31:0]       wb_pc_o,
  output logic              wb_misalign_o,
  output logic [4:0]        ctl_mem_dest_o
);

  state_e              state_q;
  logic                load_q;
  logic                sign_q;
  logic                op_we_q;
  logic [1:0]          size_q;
  logic [LANE_W-1:0]   lane_q;
  logic [DATA_W-1:0]   result_q;

  logic                accept_s;
  logic                mem_op_s;
  logic                misalign_s;
  logic [NB-1:0]       be_s;
  logic [DATA_W-1:0]   wdata_s;
  logic [DATA_W-1:0]   load_res_s;

  // DONE only frees the slot once writeback takes the result.
  assign ex_ready_o = (state_q == ST_IDLE) | ((state_q == ST_DONE) & wb_ready_i);
  assign accept_s   = ex_valid_i & ex_ready_o;
  assign mem_op_s   = ex_load_i | ex_store_i;

  assign ctl_mem_dest_o = ((state_q != ST_IDLE) & op_we_q) ? wb_wdest_o : 5'd0;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo_i    (ex_addr_i[2:0]),
    .req_size_i   (ex_size_i),
    .req_wdata_i  (ex_wdata_i),
    .misalign_o   (misalign_s),
    .be_o         (be_s),
    .wdata_o      (wdata_s),
    .rsp_lane_i   (lane_q),
    .rsp_size_i   (size_q),
    .rsp_sign_i   (sign_q),
    .rsp_rdata_i  (dm_rdata_i),
    .rsp_result_o (load_res_s)
  );

  // Transaction FSM with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      load_q        <= 1'b0;
      sign_q        <= 1'b0;
      op_we_q       <= 1'b0;
      size_q        <= 2'd0;
      lane_q        <= '0;
      result_q      <= '0;
      dm_req_o      <= 1'b0;
      dm_we_o       <= 1'b0;
      dm_addr_o     <= '0;
      dm_be_o       <= '0;
      dm_wdata_o    <= '0;
      wb_valid_o    <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_misalign_o <= 1'b0;
      wb_result_o   <= '0;
      wb_pc_o       <= 32'd0;
      wb_wdest_o    <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            wb_pc_o    <= ex_pc_i;
            wb_wdest_o <= ex_wdest_i;
            op_we_q    <= ex_we_i;
            result_q   <= ex_result_i;
            load_q     <= ex_load_i;
            sign_q     <= ex_sign_i;
            size_q     <= ex_size_i;
            lane_q     <= ex_addr_i[LANE_W-1:0];
            if (!mem_op_s) begin
              state_q       <= ST_DONE;
              wb_valid_o    <= 1'b1;
              wb_we_o       <= ex_we_i;
              wb_misalign_o <= 1'b0;
              wb_result_o   <= ex_result_i;
            end else if (misalign_s) begin
              state_q       <= ST_DONE;
              wb_valid_o    <= 1'b1;
              wb_we_o       <= 1'b0;
              wb_misalign_o <= 1'b1;
              wb_result_o   <= ex_result_i;
            end else begin
              // Load wins if both load and store are flagged.
              state_q       <= ST_REQ;
              wb_valid_o    <= 1'b0;
              wb_we_o       <= ex_load_i & ex_we_i;
              wb_misalign_o <= 1'b0;
              dm_req_o      <= 1'b1;
              dm_we_o       <= ~ex_load_i;
              dm_addr_o     <= ex_addr_i;
              dm_be_o       <= be_s;
              dm_wdata_o    <= wdata_s;
            end
          end else if ((state_q == ST_DONE) && wb_ready_i) begin
            state_q    <= ST_IDLE;
            wb_valid_o <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        ST_REQ: begin
          // A response in REQ only counts together with the grant.
          if (dm_gnt_i) begin
            dm_req_o <= 1'b0;
            dm_we_o  <= 1'b0;
            if (dm_rvalid_i) begin
              state_q     <= ST_DONE;
              wb_valid_o  <= 1'b1;
              wb_result_o <= load_q ? load_res_s : result_q;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (dm_rvalid_i) begin
            state_q     <= ST_DONE;
            wb_valid_o  <= 1'b1;
            wb_result_o <= load_q ? load_res_s : result_q;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ls_unit.sv
module tb_mem_ls_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared EX fields
  logic        ex_load = 1'b0, ex_store = 1'b0, ex_sign = 1'b0, ex_we = 1'b0;
  logic [1:0]  ex_size = 2'd0;
  logic [31:0] ex_addr = 32'd0, ex_pc = 32'd0;
  logic [4:0]  ex_wdest = 5'd0;

  // 32-bit instance
  logic        ex_valid = 1'b0, dm_gnt = 1'b0, dm_rvalid = 1'b0, wb_ready = 1'b1;
  logic [31:0] ex_wdata = 32'd0, ex_result = 32'd0, dm_rdata = 32'd0;
  logic        ex_ready, dm_req, dm_we, wb_valid, wb_we, wb_mis;
  logic [31:0] dm_addr, dm_wdata, wb_result, wb_pc;
  logic [3:0]  dm_be;
  logic [4:0]  wb_wdest, ctl_dest;

  // 64-bit instance
  logic        ex_valid64 = 1'b0, dm_gnt64 = 1'b0, dm_rvalid64 = 1'b0, wb_ready64 = 1'b1;
  logic [63:0] ex_wdata64 = 64'd0, ex_result64 = 64'd0, dm_rdata64 = 64'd0;
  logic        ex_ready64, dm_req64, dm_we64, wb_valid64, wb_we64, wb_mis64;
  logic [31:0] dm_addr64, wb_pc64;
  logic [63:0] dm_wdata64, wb_result64;
  logic [7:0]  dm_be64;
  logic [4:0]  wb_wdest64, ctl_dest64;

  int n_cmp = 0;
  int n_fail = 0;

  mem_ls_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_sign_i(ex_sign), .ex_size_i(ex_size),
    .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_result_i(ex_result),
    .ex_wdest_i(ex_wdest), .ex_we_i(ex_we), .ex_pc_i(ex_pc),
    .dm_req_o(dm_req), .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_be_o(dm_be),
    .dm_wdata_o(dm_wdata), .dm_gnt_i(dm_gnt), .dm_rvalid_i(dm_rvalid), .dm_rdata_i(dm_rdata),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_wdest_o(wb_wdest), .wb_we_o(wb_we),
    .wb_result_o(wb_result), .wb_pc_o(wb_pc), .wb_misalign_o(wb_mis), .ctl_mem_dest_o(ctl_dest)
  );

  mem_ls_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid64), .ex_ready_o(ex_ready64),
    .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_sign_i(ex_sign), .ex_size_i(ex_size),
    .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata64), .ex_result_i(ex_result64),
    .ex_wdest_i(ex_wdest), .ex_we_i(ex_we), .ex_pc_i(ex_pc),
    .dm_req_o(dm_req64), .dm_we_o(dm_we64), .dm_addr_o(dm_addr64), .dm_be_o(dm_be64),
    .dm_wdata_o(dm_wdata64), .dm_gnt_i(dm_gnt64), .dm_rvalid_i(dm_rvalid64), .dm_rdata_i(dm_rdata64),
    .wb_valid_o(wb_valid64), .wb_ready_i(wb_ready64), .wb_wdest_o(wb_wdest64), .wb_we_o(wb_we64),
    .wb_result_o(wb_result64), .wb_pc_o(wb_pc64), .wb_misalign_o(wb_mis64), .ctl_mem_dest_o(ctl_dest64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        lo, st, sg;
    logic [1:0]  sz;
    logic [31:0] addr, wdata, result;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] pc, rdata;
    logic        same;       // grant and response in the same cycle
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_res;
    logic        chk_res, exp_we, exp_mis;
  } vec_t;

  vec_t vecs[13];

  // One op on the 32-bit unit: grant next cycle, response one or two cycles later.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    ex_load = v.lo; ex_store = v.st; ex_sign = v.sg; ex_size = v.sz;
    ex_addr = v.addr; ex_wdata = v.wdata; ex_result = v.result;
    ex_wdest = v.dest; ex_we = v.we; ex_pc = v.pc; ex_valid = 1'b1;
    #1 chk("ex_ready", ex_ready, 1'b1);
    @(posedge clk); #1 ex_valid = 1'b0;
    if (v.exp_req) begin
      chk("dm_req", dm_req, 1'b1);
      chk("dm_addr", dm_addr, v.addr);
      chk("dm_we", dm_we, v.st);
      chk("dm_be", dm_be, v.exp_be);
      if (v.st) chk("dm_wdata", dm_wdata, v.exp_wdata);
      chk("ctl_dest_req", ctl_dest, v.we ? v.dest : 5'd0);
      dm_gnt = 1'b1;
      if (v.same) begin dm_rvalid = 1'b1; dm_rdata = v.rdata; end
      @(posedge clk); #1 dm_gnt = 1'b0;
      chk("dm_req_drop", dm_req, 1'b0);
      if (!v.same) begin
        chk("wb_valid_wait", wb_valid, 1'b0);
        dm_rvalid = 1'b1; dm_rdata = v.rdata;
        @(posedge clk); #1;
      end
      dm_rvalid = 1'b0;
    end else begin
      chk("dm_req_none", dm_req, 1'b0);
    end
    chk("wb_valid", wb_valid, 1'b1);
    chk("wb_we", wb_we, v.exp_we);
    chk("wb_misalign", wb_mis, v.exp_mis);
    chk("wb_pc", wb_pc, v.pc);
    chk("wb_wdest", wb_wdest, v.dest);
    if (v.chk_res) chk("wb_result", wb_result, v.exp_res);
  endtask

  task automatic run64(input logic lo, input logic st, input logic sg, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                       input logic [7:0] exp_be, input logic [63:0] exp_wdata, input logic [63:0] exp_res);
    @(negedge clk);
    ex_load = lo; ex_store = st; ex_sign = sg; ex_size = sz; ex_addr = addr;
    ex_wdata64 = wdata; ex_result64 = 64'h5555_0000_0000_5555; ex_we = 1'b1;
    ex_wdest = 5'd4; ex_pc = 32'h3000; ex_valid64 = 1'b1;
    @(posedge clk); #1 ex_valid64 = 1'b0;
    chk("d64_req", dm_req64, 1'b1);
    chk("d64_be", dm_be64, exp_be);
    if (st) chk("d64_wdata", dm_wdata64, exp_wdata);
    dm_gnt64 = 1'b1; dm_rvalid64 = 1'b1; dm_rdata64 = rdata;
    @(posedge clk); #1 dm_gnt64 = 1'b0; dm_rvalid64 = 1'b0;
    chk("d64_wb_valid", wb_valid64, 1'b1);
    chk("d64_wb_result", wb_result64, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              lo   st   sg   sz    addr       wdata         result        dest  we   pc         rdata        same req be       exp_wdata     exp_res       cr   we   mis
    vecs[0]  = '{1'b0,1'b0,1'b0,2'd2,32'h0000_0000,32'h0,        32'hCAFE_0001,5'd5,1'b1,32'h1000,32'h0,        1'b0,1'b0,4'b0000,32'h0,        32'hCAFE_0001,1'b1,1'b1,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,2'd1,32'h0000_0202,32'h1234_ABCD,32'h1111_1111,5'd6,1'b0,32'h1004,32'h0,        1'b0,1'b1,4'b1100,32'hABCD_ABCD,32'h1111_1111,1'b1,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,2'd2,32'h0000_0102,32'h0,        32'h2222_2222,5'd7,1'b1,32'h1008,32'h0,        1'b0,1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b0,1'b1};
    vecs[3]  = '{1'b1,1'b0,1'b0,2'd0,32'h0000_0101,32'h0,        32'h0,        5'd8,1'b1,32'h100C,32'h1234_8056,1'b0,1'b1,4'b0010,32'h0,        32'h0000_0080,1'b1,1'b1,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b1,2'd1,32'h0000_0102,32'h0,        32'h0,        5'd9,1'b1,32'h1010,32'h8001_7FFF,1'b0,1'b1,4'b1100,32'h0,        32'hFFFF_8001,1'b1,1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0,2'd1,32'h0000_0100,32'h0,        32'h0,        5'd10,1'b1,32'h1014,32'h1234_8765,1'b1,1'b1,4'b0011,32'h0,       32'h0000_8765,1'b1,1'b1,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b1,2'd2,32'h0000_0104,32'h0,        32'h0,        5'd11,1'b1,32'h1018,32'hA5A5_5A5A,1'b1,1'b1,4'b1111,32'h0,       32'hA5A5_5A5A,1'b1,1'b1,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,2'd0,32'h0000_0003,32'h0000_00EE,32'h3333_3333,5'd12,1'b1,32'h101C,32'h0,       1'b0,1'b1,4'b1000,32'hEEEE_EEEE,32'h3333_3333,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b0,2'd2,32'h0000_0008,32'h0123_4567,32'h4444_4444,5'd13,1'b0,32'h1020,32'h0,       1'b1,1'b1,4'b1111,32'h0123_4567,32'h4444_4444,1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b1,2'd1,32'h0000_0101,32'h0,        32'h0,        5'd14,1'b1,32'h1024,32'h0,        1'b0,1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b0,1'b1};
    vecs[10] = '{1'b1,1'b0,1'b0,2'd3,32'h0000_0000,32'h0,        32'h0,        5'd15,1'b1,32'h1028,32'h0,        1'b0,1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b0,1'b1};
    vecs[11] = '{1'b0,1'b1,1'b0,2'd1,32'h0000_0203,32'h0000_BEEF,32'h0,        5'd16,1'b0,32'h102C,32'h0,        1'b0,1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b0,1'b1};
    vecs[12] = '{1'b1,1'b0,1'b1,2'd0,32'h0000_0002,32'h0,        32'h0,        5'd17,1'b1,32'h1030,32'h0070_0000,1'b0,1'b1,4'b0100,32'h0,       32'h0000_0070,1'b1,1'b1,1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_dm_req", dm_req, 1'b0);
    chk("rst_ex_ready", ex_ready, 1'b1);
    chk("rst_wb_result", wb_result, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // lb signed at 0x103: grant in cycle 1, response in cycle 3, result in cycle 4
    repeat (2) @(posedge clk);
    @(negedge clk);
    ex_load = 1'b1; ex_store = 1'b0; ex_sign = 1'b1; ex_size = 2'd0; ex_addr = 32'h103;
    ex_result = 32'h0; ex_wdest = 5'd20; ex_we = 1'b1; ex_pc = 32'h1100; ex_valid = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0;
    chk("lb_be", dm_be, 4'b1000);
    dm_gnt = 1'b1;
    @(posedge clk); #1 dm_gnt = 1'b0;
    chk("lb_c2_valid", wb_valid, 1'b0);
    chk("lb_ctl_dest", ctl_dest, 5'd20);
    @(posedge clk); #1;
    chk("lb_c3_valid", wb_valid, 1'b0);
    dm_rvalid = 1'b1; dm_rdata = 32'h80FF_0000;
    @(posedge clk); #1 dm_rvalid = 1'b0;
    chk("lb_c4_valid", wb_valid, 1'b1);
    chk("lb_result", wb_result, 32'hFFFF_FF80);

    // Writeback stall for 5 cycles, then back-to-back accept
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb_ready = 1'b0;
    ex_load = 1'b0; ex_store = 1'b0; ex_result = 32'hAAAA_0001; ex_wdest = 5'd21;
    ex_we = 1'b1; ex_pc = 32'h2000; ex_valid = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", wb_valid, 1'b1);
      chk("stall_result", wb_result, 32'hAAAA_0001);
      chk("stall_pc", wb_pc, 32'h2000);
      chk("stall_ex_ready", ex_ready, 1'b0);
      chk("stall_ctl_dest", ctl_dest, 5'd21);
      @(posedge clk); #1;
    end
    @(negedge clk);
    wb_ready = 1'b1; ex_result = 32'hBBBB_0002; ex_pc = 32'h2004; ex_valid = 1'b1;
    #1 chk("b2b_ex_ready", ex_ready, 1'b1);
    @(posedge clk); #1 ex_valid = 1'b0;
    chk("b2b_valid", wb_valid, 1'b1);
    chk("b2b_result", wb_result, 32'hBBBB_0002);
    chk("b2b_pc", wb_pc, 32'h2004);

    // Reset while waiting for the response; the late response is dropped
    repeat (2) @(posedge clk);
    @(negedge clk);
    ex_load = 1'b1; ex_sign = 1'b0; ex_size = 2'd2; ex_addr = 32'h200; ex_wdest = 5'd3;
    ex_we = 1'b1; ex_pc = 32'h2100; ex_valid = 1'b1;
    @(posedge clk); #1 ex_valid = 1'b0; dm_gnt = 1'b1;
    @(posedge clk); #1 dm_gnt = 1'b0;
    chk("rw_in_wait", dm_req, 1'b0);
    rst_n = 1'b0;
    #1 chk("rw_async_ctl", ctl_dest, 5'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) begin dm_rvalid = 1'b1; dm_rdata = 32'hFFFF_FFFF; end
    @(posedge clk); #1 dm_rvalid = 1'b0;
    chk("rw_wb_valid", wb_valid, 1'b0);
    chk("rw_wb_result", wb_result, 32'h0);
    chk("rw_wb_pc", wb_pc, 32'h0);
    chk("rw_wb_wdest", wb_wdest, 5'd0);
    chk("rw_wb_we", wb_we, 1'b0);
    chk("rw_dm_addr", dm_addr, 32'h0);
    chk("rw_dm_be", dm_be, 4'h0);
    chk("rw_ctl_dest", ctl_dest, 5'd0);
    chk("rw_ex_ready", ex_ready, 1'b1);
    @(posedge clk); #1;
    chk("rw_still_idle", wb_valid, 1'b0);

    // 64-bit data path
    run64(1'b1, 1'b0, 1'b0, 2'd2, 32'h4, 64'h0, 64'hDEAD_BEEF_0000_0001,
          8'hF0, 64'h0, 64'h0000_0000_DEAD_BEEF);
    run64(1'b1, 1'b0, 1'b1, 2'd1, 32'h6, 64'h0, 64'h8000_1234_5678_9ABC,
          8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8000);
    run64(1'b0, 1'b1, 1'b0, 2'd3, 32'h8, 64'h0102_0304_0506_0708, 64'h0,
          8'hFF, 64'h0102_0304_0506_0708, 64'h5555_0000_0000_5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
